l1_req_arb: RTL and testbench
=============================

L1_REQ_ARB -- requirements
Module: l1_req_arb

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive L1D grants allowed while L1I waits before L1I is forced.
REQ-002 Parameter TIMEOUT, default 255: max cycles mem_req_val may wait for mem_req_ack; 0 disables watchdog.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 l1i_req_val  in  1  L1I line-refill request, level, held until l1i_req_ack.
REQ-007 l1i_req_addr  in  CORE_ADDR_WIDTH  L1I refill address.
REQ-008 l1i_req_ack  out  1  one-cycle completion pulse to L1I.
REQ-009 l1i_ack_data  out  L1_LINE_SIZE  refill line, valid with l1i_req_ack.
REQ-010 l1i_ack_err  out  1  timeout error, valid with l1i_req_ack.
REQ-011 l1d_req_val  in  1  L1D request, level, held until l1d_req_ack.
REQ-012 l1d_req_we / l1d_req_addr / l1d_req_wdata / l1d_req_be  in  1 / CORE_ADDR_WIDTH / CORE_DATA_WIDTH / CORE_BE_WIDTH  L1D payload.
REQ-013 l1d_req_ack / l1d_ack_data / l1d_ack_err  out  1 / L1_LINE_SIZE / 1  as L1I counterparts.
REQ-014 mem_req_val / mem_req_we / mem_req_addr / mem_req_wdata / mem_req_be  out  widths as L1D payload  request to memory access unit.
REQ-015 mem_req_ack  in  1  one-cycle completion pulse from memory access unit.
REQ-016 mem_ack_data  in  L1_LINE_SIZE  line data, valid with mem_req_ack.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D; all outputs registered.
REQ-019 IDLE: no val -> IDLE; only one val -> BUSY of that requester; both val -> BUSY_D unless starve_cnt == STARVE_MAX, then BUSY_I.
REQ-020 On IDLE->BUSY_x the arbiter SHALL capture the requester payload into mem_req_* (L1I: we=0, wdata=0, be=0) and assert mem_req_val the next cycle (val at cycle 0 -> mem_req_val at cycle 1).
REQ-021 mem_req_val and payload SHALL stay constant in BUSY_x until the cycle mem_req_ack is sampled high.
REQ-022 mem_req_ack in BUSY_x -> RESP_x next cycle: mem_req_val=0, lx_req_ack=1 for exactly one cycle, lx_ack_data = captured mem_ack_data, lx_ack_err=0.
REQ-023 RESP_x SHALL always go to IDLE; requester val sampled in IDLE after RESP is treated as a new request.
REQ-024 starve_cnt (width clog2(STARVE_MAX+1)): +1 on D grant with l1i_req_val high, cleared on D grant with l1i_req_val low, cleared on any I grant; saturates at STARVE_MAX.
REQ-025 Watchdog counter SHALL clear on entering BUSY_x and increment each BUSY_x cycle without mem_req_ack; reaching TIMEOUT -> RESP_x with lx_ack_err=1, lx_ack_data=0, mem_req_val dropped.
REQ-026 mem_req_ack sampled in IDLE or RESP_x SHALL be ignored (no state, data or counter change).
REQ-027 mem_req_ack and watchdog expiry in the same cycle: ack wins, err=0.
REQ-028 l1x_ack_data SHALL hold its last value outside RESP_x; l1x_req_ack and l1x_ack_err SHALL be 0 outside RESP_x.

Reset
REQ-029 rst_n low at a clock edge SHALL force IDLE, starve_cnt=0, watchdog=0, every output 0, including mid-BUSY or mid-RESP.
REQ-030 An in-flight request aborted by reset SHALL NOT be acked; requesters re-issue after reset.

Verification
REQ-031 L1I only, addr 0x100, mem_req_ack 3 cycles after mem_req_val, data 0xA5..: mem_req_val cycle 1, l1i_req_ack cycle 5 with that data, err=0, busy low cycle 6.
REQ-032 L1I and L1D held continuously, STARVE_MAX=4, immediate acks: grant order D,D,D,D,I,D,D,D,D,I.
REQ-033 L1D write we=1, be=0xF, wdata 0xDEADBEEF: mem_req_* carries exact payload stable until ack; l1d_req_ack one cycle.
REQ-034 TIMEOUT=8, no mem_req_ack: mem_req_val high 8 cycles, then l1d_req_ack=1, l1d_ack_err=1, data 0; later stray mem_req_ack in IDLE causes no ack.
REQ-035 rst_n low during BUSY_D: next cycle all outputs 0, IDLE; no l1d_req_ack; L1D re-issue after reset completes normally.
REQ-036 mem_req_ack on the exact cycle watchdog hits TIMEOUT=8: ack with err=0 and mem_ack_data.

Source files
------------

// File: rtl/l1_req_arb.sv
// rtl/l1_req_arb.sv - two-requester (L1I/L1D) arbiter onto a single memory request port
module l1_req_arb #(
    parameter int STARVE_MAX      = 4,
    parameter int TIMEOUT         = 255,
    parameter int CORE_ADDR_WIDTH = 32,
    parameter int CORE_DATA_WIDTH = 32,
    parameter int CORE_BE_WIDTH   = 4,
    parameter int L1_LINE_SIZE    = 128
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       l1i_req_val,
    input  logic [CORE_ADDR_WIDTH-1:0] l1i_req_addr,
    output logic                       l1i_req_ack,
    output logic [L1_LINE_SIZE-1:0]    l1i_ack_data,
    output logic                       l1i_ack_err,
    input  logic                       l1d_req_val,
    input  logic                       l1d_req_we,
    input  logic [CORE_ADDR_WIDTH-1:0] l1d_req_addr,
    input  logic [CORE_DATA_WIDTH-1:0] l1d_req_wdata,
    input  logic [CORE_BE_WIDTH-1:0]   l1d_req_be,
    output logic                       l1d_req_ack,
    output logic [L1_LINE_SIZE-1:0]    l1d_ack_data,
    output logic                       l1d_ack_err,
    output logic                       mem_req_val,
    output logic                       mem_req_we,
    output logic [CORE_ADDR_WIDTH-1:0] mem_req_addr,
    output logic [CORE_DATA_WIDTH-1:0] mem_req_wdata,
    output logic [CORE_BE_WIDTH-1:0]   mem_req_be,
    input  logic                       mem_req_ack,
    input  logic [L1_LINE_SIZE-1:0]    mem_ack_data,
    output logic                       busy
);

    // Counter widths stay at least one bit so a zero parameter still elaborates.
    localparam int ST_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [ST_W-1:0] ST_MAX  = ST_W'(STARVE_MAX);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit              WD_EN   = (TIMEOUT > 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } state_t;

    state_t                     state_q;
    logic [ST_W-1:0]            starve_q;
    logic [WD_W-1:0]            wd_q;
    logic                       mem_req_val_q;
    logic                       mem_req_we_q;
    logic [CORE_ADDR_WIDTH-1:0] mem_req_addr_q;
    logic [CORE_DATA_WIDTH-1:0] mem_req_wdata_q;
    logic [CORE_BE_WIDTH-1:0]   mem_req_be_q;
    logic                       l1i_req_ack_q;
    logic [L1_LINE_SIZE-1:0]    l1i_ack_data_q;
    logic                       l1i_ack_err_q;
    logic                       l1d_req_ack_q;
    logic [L1_LINE_SIZE-1:0]    l1d_ack_data_q;
    logic                       l1d_ack_err_q;
    logic                       busy_q;

    // D wins a tie unless L1I has already been passed over STARVE_MAX times in a row.
    logic grant_d;
    logic grant_i;
    logic wd_expire;

    // Grant decode and watchdog expiry are pure functions of the sampled state.
    always_comb begin
        grant_d   = l1d_req_val && !(l1i_req_val && (starve_q == ST_MAX));
        grant_i   = l1i_req_val && !grant_d;
        wd_expire = WD_EN && (wd_q == WD_LAST);
    end

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            starve_q        <= '0;
            wd_q            <= '0;
            mem_req_val_q   <= 1'b0;
            mem_req_we_q    <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_wdata_q <= '0;
            mem_req_be_q    <= '0;
            l1i_req_ack_q   <= 1'b0;
            l1i_ack_data_q  <= '0;
            l1i_ack_err_q   <= 1'b0;
            l1d_req_ack_q   <= 1'b0;
            l1d_ack_data_q  <= '0;
            l1d_ack_err_q   <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            // Completion strobes are single-cycle; only the RESP transition raises them.
            l1i_req_ack_q <= 1'b0;
            l1i_ack_err_q <= 1'b0;
            l1d_req_ack_q <= 1'b0;
            l1d_ack_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q         <= BUSY_D;
                        busy_q          <= 1'b1;
                        wd_q            <= '0;
                        mem_req_val_q   <= 1'b1;
                        mem_req_we_q    <= l1d_req_we;
                        mem_req_addr_q  <= l1d_req_addr;
                        mem_req_wdata_q <= l1d_req_wdata;
                        mem_req_be_q    <= l1d_req_be;
                        if (!l1i_req_val) begin
                            starve_q <= '0;
                        end else if (starve_q != ST_MAX) begin
                            starve_q <= starve_q + ST_W'(1);
                        end
                    end else if (grant_i) begin
                        state_q         <= BUSY_I;
                        busy_q          <= 1'b1;
                        wd_q            <= '0;
                        starve_q        <= '0;
                        mem_req_val_q   <= 1'b1;
                        mem_req_we_q    <= 1'b0;
                        mem_req_addr_q  <= l1i_req_addr;
                        mem_req_wdata_q <= '0;
                        mem_req_be_q    <= '0;
                    end
                end
                BUSY_I: begin
                    if (mem_req_ack) begin
                        state_q        <= RESP_I;
                        mem_req_val_q  <= 1'b0;
                        l1i_req_ack_q  <= 1'b1;
                        l1i_ack_data_q <= mem_ack_data;
                    end else if (wd_expire) begin
                        state_q        <= RESP_I;
                        mem_req_val_q  <= 1'b0;
                        l1i_req_ack_q  <= 1'b1;
                        l1i_ack_err_q  <= 1'b1;
                        l1i_ack_data_q <= '0;
                    end else if (WD_EN) begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                BUSY_D: begin
                    if (mem_req_ack) begin
                        state_q        <= RESP_D;
                        mem_req_val_q  <= 1'b0;
                        l1d_req_ack_q  <= 1'b1;
                        l1d_ack_data_q <= mem_ack_data;
                    end else if (wd_expire) begin
                        state_q        <= RESP_D;
                        mem_req_val_q  <= 1'b0;
                        l1d_req_ack_q  <= 1'b1;
                        l1d_ack_err_q  <= 1'b1;
                        l1d_ack_data_q <= '0;
                    end else if (WD_EN) begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                RESP_I, RESP_D: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_val   = mem_req_val_q;
    assign mem_req_we    = mem_req_we_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign mem_req_wdata = mem_req_wdata_q;
    assign mem_req_be    = mem_req_be_q;
    assign l1i_req_ack   = l1i_req_ack_q;
    assign l1i_ack_data  = l1i_ack_data_q;
    assign l1i_ack_err   = l1i_ack_err_q;
    assign l1d_req_ack   = l1d_req_ack_q;
    assign l1d_ack_data  = l1d_ack_data_q;
    assign l1d_ack_err   = l1d_ack_err_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_l1_req_arb.sv
// tb/tb_l1_req_arb.sv - scoreboard bench for l1_req_arb
module tb_l1_req_arb;

    logic         clk;
    logic         rst_n;
    logic         l1i_req_val;
    logic [31:0]  l1i_req_addr;
    logic         l1i_req_ack;
    logic [127:0] l1i_ack_data;
    logic         l1i_ack_err;
    logic         l1d_req_val;
    logic         l1d_req_we;
    logic [31:0]  l1d_req_addr;
    logic [31:0]  l1d_req_wdata;
    logic [3:0]   l1d_req_be;
    logic         l1d_req_ack;
    logic [127:0] l1d_ack_data;
    logic         l1d_ack_err;
    logic         mem_req_val;
    logic         mem_req_we;
    logic [31:0]  mem_req_addr;
    logic [31:0]  mem_req_wdata;
    logic [3:0]   mem_req_be;
    logic         mem_req_ack;
    logic [127:0] mem_ack_data;
    logic         busy;

    l1_req_arb #(
        .STARVE_MAX(4), .TIMEOUT(8), .CORE_ADDR_WIDTH(32),
        .CORE_DATA_WIDTH(32), .CORE_BE_WIDTH(4), .L1_LINE_SIZE(128)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .l1i_req_val(l1i_req_val), .l1i_req_addr(l1i_req_addr),
        .l1i_req_ack(l1i_req_ack), .l1i_ack_data(l1i_ack_data), .l1i_ack_err(l1i_ack_err),
        .l1d_req_val(l1d_req_val), .l1d_req_we(l1d_req_we), .l1d_req_addr(l1d_req_addr),
        .l1d_req_wdata(l1d_req_wdata), .l1d_req_be(l1d_req_be),
        .l1d_req_ack(l1d_req_ack), .l1d_ack_data(l1d_ack_data), .l1d_ack_err(l1d_ack_err),
        .mem_req_val(mem_req_val), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
        .mem_req_ack(mem_req_ack), .mem_ack_data(mem_ack_data), .busy(busy)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_t;

    typedef struct packed {
        logic         is_i;
        logic [127:0] data;
        logic         err;
    } ack_t;

    mem_t exp_mem[$];
    ack_t exp_ack[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void push_mem(logic we, logic [31:0] a, logic [31:0] wd, logic [3:0] be);
        mem_t m;
        m.we = we; m.addr = a; m.wdata = wd; m.be = be;
        exp_mem.push_back(m);
    endfunction

    function automatic void push_ack(logic is_i, logic [127:0] d, logic err);
        ack_t e;
        e.is_i = is_i; e.data = d; e.err = err;
        exp_ack.push_back(e);
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    // Monitor: pops expected request/response entries as the DUT presents them.
    mem_t cur;
    logic have_cur = 1'b0;
    ack_t e_ack;
    always @(negedge clk) begin
        if (mem_req_val) begin
            if (!have_cur) begin
                if (exp_mem.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL mem_req_unexpected: got addr %0h expected no request", mem_req_addr);
                end else begin
                    cur = exp_mem.pop_front();
                    have_cur = 1'b1;
                end
            end
            if (have_cur)
                chk("mem_req_payload", {mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be}, cur);
        end else begin
            have_cur = 1'b0;
        end
        if (l1i_req_ack || l1d_req_ack) begin
            chk("ack_exclusive", l1i_req_ack & l1d_req_ack, 0);
            if (exp_ack.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL ack_unexpected: got i=%0b d=%0b expected no ack", l1i_req_ack, l1d_req_ack);
            end else begin
                e_ack = exp_ack.pop_front();
                chk("ack_port_is_i", l1i_req_ack, e_ack.is_i);
                chk("ack_data", l1i_req_ack ? l1i_ack_data : l1d_ack_data, e_ack.data);
                chk("ack_err", l1i_req_ack ? l1i_ack_err : l1d_ack_err, e_ack.err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory side: wait for a request, hold off dly cycles, then pulse mem_req_ack.
    task automatic serve(input int dly, input logic [127:0] d);
        int k;
        k = 0;
        while (!mem_req_val && k < 50) begin
            tick();
            k++;
        end
        chk("serve_req_seen", mem_req_val, 1);
        repeat (dly) tick();
        mem_req_ack  = 1'b1;
        mem_ack_data = d;
        tick();
        mem_req_ack  = 1'b0;
    endtask

    logic [127:0] d;
    int           cnt;
    logic         seen;

    initial begin
        rst_n = 1'b0;
        l1i_req_val = 1'b0; l1i_req_addr = '0;
        l1d_req_val = 1'b0; l1d_req_we = 1'b0; l1d_req_addr = '0;
        l1d_req_wdata = '0; l1d_req_be = '0;
        mem_req_ack = 1'b0; mem_ack_data = '0;
        tick(); tick();
        chk("rst_mem_req_val", mem_req_val, 0);
        chk("rst_busy", busy, 0);
        chk("rst_acks", {l1i_req_ack, l1d_req_ack, l1i_ack_err, l1d_ack_err}, 0);
        chk("rst_data", l1i_ack_data | l1d_ack_data, 0);
        rst_n = 1'b1;

        // L1I refill, ack three cycles after mem_req_val
        l1i_req_val = 1'b1; l1i_req_addr = 32'h100;
        push_mem(1'b0, 32'h100, 32'h0, 4'h0);
        push_ack(1'b1, {16{8'hA5}}, 1'b0);
        tick();
        chk("t1_memval_cycle1", mem_req_val, 1);
        chk("t1_busy_cycle1", busy, 1);
        tick(); tick(); tick();
        mem_req_ack = 1'b1; mem_ack_data = {16{8'hA5}};
        tick();
        mem_req_ack = 1'b0;
        chk("t1_ack_cycle5", l1i_req_ack, 1);
        chk("t1_memval_dropped", mem_req_val, 0);
        l1i_req_val = 1'b0;
        tick();
        chk("t1_busy_cycle6", busy, 0);
        chk("t1_ack_one_cycle", l1i_req_ack, 0);

        // Both requesters held: grant order D,D,D,D,I,D,D,D,D,I
        l1i_req_val = 1'b1; l1i_req_addr = 32'h200;
        l1d_req_val = 1'b1; l1d_req_we = 1'b0; l1d_req_addr = 32'h300;
        l1d_req_wdata = 32'h1111_1111; l1d_req_be = 4'h3;
        for (int g = 0; g < 10; g++) begin
            if (g == 4 || g == 9) begin
                push_mem(1'b0, 32'h200, 32'h0, 4'h0);
                push_ack(1'b1, {4{32'hC0DE_0000 + g}}, 1'b0);
            end else begin
                push_mem(1'b0, 32'h300, 32'h1111_1111, 4'h3);
                push_ack(1'b0, {4{32'hC0DE_0000 + g}}, 1'b0);
            end
        end
        for (int g = 0; g < 10; g++) serve(0, {4{32'hC0DE_0000 + g}});
        l1i_req_val = 1'b0; l1d_req_val = 1'b0;
        tick(); tick();

        // L1D write payload carried unchanged until ack
        l1d_req_val = 1'b1; l1d_req_we = 1'b1; l1d_req_addr = 32'h400;
        l1d_req_wdata = 32'hDEAD_BEEF; l1d_req_be = 4'hF;
        push_mem(1'b1, 32'h400, 32'hDEAD_BEEF, 4'hF);
        push_ack(1'b0, {4{32'h0BAD_F00D}}, 1'b0);
        serve(2, {4{32'h0BAD_F00D}});
        chk("t3_ack", l1d_req_ack, 1);
        l1d_req_val = 1'b0;
        tick();
        chk("t3_ack_one_cycle", l1d_req_ack, 0);
        tick();

        // Watchdog expiry with no mem_req_ack
        l1d_req_val = 1'b1; l1d_req_we = 1'b0; l1d_req_addr = 32'h500;
        l1d_req_wdata = 32'h0; l1d_req_be = 4'h0;
        push_mem(1'b0, 32'h500, 32'h0, 4'h0);
        push_ack(1'b0, 128'h0, 1'b1);
        cnt = 0; seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (mem_req_val) cnt++;
            if (l1d_req_ack) seen = 1'b1;
        end
        chk("t4_ack_seen", seen, 1);
        chk("t4_memval_cycles", cnt, 8);
        chk("t4_err", l1d_ack_err, 1);
        l1d_req_val = 1'b0;
        tick(); tick();
        mem_req_ack = 1'b1; mem_ack_data = {4{32'hFFFF_FFFF}};
        tick();
        mem_req_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t4_stray_no_ack", {l1i_req_ack, l1d_req_ack, busy}, 0);
            chk("t4_d_data_held", l1d_ack_data, 128'h0);
            tick();
        end
        chk("t4_i_data_held", l1i_ack_data, {4{32'hC0DE_0009}});

        // Reset in BUSY_D aborts silently; re-issued request completes
        l1d_req_val = 1'b1; l1d_req_addr = 32'h700;
        push_mem(1'b0, 32'h700, 32'h0, 4'h0);
        tick(); tick();
        chk("t5_busy_before", busy, 1);
        rst_n = 1'b0; l1d_req_val = 1'b0;
        tick();
        chk("t5_rst_memval", mem_req_val, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_payload", {mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be}, 0);
        chk("t5_rst_acks", {l1i_req_ack, l1d_req_ack, l1i_ack_err, l1d_ack_err}, 0);
        chk("t5_rst_data", l1i_ack_data | l1d_ack_data, 0);
        rst_n = 1'b1;
        tick();
        chk("t5_no_ack", l1d_req_ack, 0);
        l1d_req_val = 1'b1;
        push_mem(1'b0, 32'h700, 32'h0, 4'h0);
        push_ack(1'b0, {4{32'h7777_0001}}, 1'b0);
        serve(1, {4{32'h7777_0001}});
        chk("t5_reissue_ack", l1d_req_ack, 1);
        l1d_req_val = 1'b0;
        tick(); tick();

        // mem_req_ack on the cycle the watchdog would expire: ack wins
        l1d_req_val = 1'b1; l1d_req_addr = 32'h600;
        push_mem(1'b0, 32'h600, 32'h0, 4'h0);
        push_ack(1'b0, {4{32'h6666_0002}}, 1'b0);
        serve(7, {4{32'h6666_0002}});
        chk("t6_ack", l1d_req_ack, 1);
        chk("t6_err", l1d_ack_err, 0);
        chk("t6_data", l1d_ack_data, {4{32'h6666_0002}});
        l1d_req_val = 1'b0;

        repeat (5) tick();
        chk("exp_mem_drained", exp_mem.size(), 0);
        chk("exp_ack_drained", exp_ack.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
